// File: rtl/adder3_pkg.sv
// Shared types and constants for the 3-bit streaming adder stage.
package adder3_pkg;

    localparam int unsigned OPW = 3;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic           cin;
    } operand_t;

    typedef struct packed {
        logic [OPW-1:0] sum;
        logic           cout;
    } result_t;

endpackage

// File: rtl/adder3_stream_stage_rca3_core.sv
// Purely combinational 3-stage ripple-carry adder built from full-adder equations.
module rca3_core
    import adder3_pkg::*;
(
    input  logic [OPW-1:0] a_i,
    input  logic [OPW-1:0] b_i,
    input  logic           cin_i,
    output logic [OPW-1:0] sum_o,
    output logic           cout_o
);

    logic [OPW:0] carry;

    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < int'(OPW); i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[OPW];
    end

endmodule

// File: rtl/adder3_stream_stage.sv
// Operand FIFO feeding a ripple-carry core into a registered result slot,
// with a saturating count of carry-out results.
module adder3_stream_stage
    import adder3_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPW-1:0]          in_a,
    input  logic [OPW-1:0]          in_b,
    input  logic                    in_cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OPW-1:0]          out_sum,
    output logic                    out_cout,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [CNT_W-1:0]        ovf_cnt,
    input  logic                    clr_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    operand_t               mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   out_valid_q, out_valid_d;
    result_t                res_q, res_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    operand_t               beat_in;
    operand_t               head;
    result_t                core_res;
    logic                   push;
    logic                   load;

    assign in_ready = !rst && (occ_q < OCC_W'(DEPTH));
    assign beat_in  = '{a: in_a, b: in_b, cin: in_cin};
    assign head     = mem_q[rd_ptr_q];

    rca3_core u_core (
        .a_i    (head.a),
        .b_i    (head.b),
        .cin_i  (head.cin),
        .sum_o  (core_res.sum),
        .cout_o (core_res.cout)
    );

    // Load whenever a beat is waiting and the result slot is free or draining.
    always_comb begin
        push        = in_valid && in_ready;
        load        = (occ_q != '0) && (!out_valid_q || out_ready);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        cnt_d       = cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (load) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            res_d       = core_res;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        occ_d = occ_q + OCC_W'(push) - OCC_W'(load);

        if (clr_cnt) begin
            cnt_d = '0;
        end else if (load && core_res.cout && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            cnt_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
        end
    end

    // Payload storage needs no reset; occupancy alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= beat_in;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = res_q.sum;
    assign out_cout  = res_q.cout;
    assign occupancy = occ_q;
    assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_adder3_stream_stage.sv
// Directed bench for adder3_stream_stage (DEPTH=2, CNT_W=2): vector table plus
// hand-written backpressure, counter-clear and mid-stream reset sequences.
module tb_adder3_stream_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic       in_cin;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sum;
    logic       out_cout;
    logic [1:0] occupancy;
    logic [1:0] ovf_cnt;
    logic       clr_cnt;

    adder3_stream_stage #(.DEPTH(2), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .occupancy (occupancy),
        .ovf_cnt   (ovf_cnt),
        .clr_cnt   (clr_cnt)
    );

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic [2:0] sum;
        logic       cout;
        int         ovf;
    } vec_t;

    vec_t       tbl [9];
    logic [3:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         pops  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: scoreboard any handshake about to complete, then advance.
    task automatic step();
        logic [3:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", int'({out_cout, out_sum}), int'(e));
                pops++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(4'(in_a) + 4'(in_b) + 4'(in_cin));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic c);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) step();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int stalls;
        int pops0;
        int guard;
        logic acc;

        tbl[0] = '{3'd3, 3'd5, 1'b0, 3'd0, 1'b1, 1};
        tbl[1] = '{3'd2, 3'd1, 1'b1, 3'd4, 1'b0, 1};
        tbl[2] = '{3'd7, 3'd7, 1'b1, 3'd7, 1'b1, 2};
        tbl[3] = '{3'd6, 3'd1, 1'b0, 3'd7, 1'b0, 2};
        tbl[4] = '{3'd0, 3'd0, 1'b1, 3'd1, 1'b0, 2};
        tbl[5] = '{3'd4, 3'd4, 1'b0, 3'd0, 1'b1, 3};
        tbl[6] = '{3'd5, 3'd2, 1'b1, 3'd0, 1'b1, 3};
        tbl[7] = '{3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3};
        tbl[8] = '{3'd7, 3'd1, 1'b0, 3'd0, 1'b1, 3};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_occupancy", int'(occupancy), 0);
        check("rst_ovf_cnt", int'(ovf_cnt), 0);
        check("rst_out_sum", int'({out_cout, out_sum}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        // Single-beat vectors: result appears exactly one edge after acceptance.
        foreach (tbl[i]) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].cin);
            step();
            in_valid = 1'b0;
            check("vec_valid_k", int'(out_valid), 0);
            step();
            check("vec_valid_k1", int'(out_valid), 1);
            check("vec_sum", int'(out_sum), int'(tbl[i].sum));
            check("vec_cout", int'(out_cout), int'(tbl[i].cout));
            check("vec_ovf", int'(ovf_cnt), tbl[i].ovf);
        end
        step();
        drain(4);

        // All 128 operand combinations back to back at full rate.
        stalls = 0;
        pops0  = pops;
        for (int i = 0; i < 128; i++) begin
            drive(3'(i >> 4), 3'(i >> 1), 1'(i));
            if (!in_ready) stalls++;
            step();
        end
        in_valid = 1'b0;
        check("stream_stalls", stalls, 0);
        check("stream_results_inflight", pops - pops0, 126);
        drain(6);
        check("stream_results_total", pops - pops0, 128);
        check("stream_ovf_sat", int'(ovf_cnt), 3);

        // Backpressure: hold out_ready low until the FIFO fills.
        out_ready = 1'b0;
        drive(3'd1, 3'd1, 1'b0);
        step();
        check("bp_occ1", int'(occupancy), 1);
        check("bp_valid0", int'(out_valid), 0);
        drive(3'd2, 3'd2, 1'b0);
        step();
        check("bp_valid1", int'(out_valid), 1);
        check("bp_sum_first", int'(out_sum), 2);
        check("bp_occ1b", int'(occupancy), 1);
        drive(3'd3, 3'd3, 1'b0);
        step();
        check("bp_occ2", int'(occupancy), 2);
        check("bp_in_ready_low", int'(in_ready), 0);
        drive(3'd4, 3'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_stall_ready", int'(in_ready), 0);
            check("bp_stall_occ", int'(occupancy), 2);
            check("bp_stall_sum", int'({out_cout, out_sum}), 2);
            check("bp_stall_valid", int'(out_valid), 1);
        end
        pops0     = pops;
        out_ready = 1'b1;
        guard     = 0;
        acc       = 1'b0;
        while (!acc && guard < 10) begin
            acc = in_ready;
            step();
            guard++;
        end
        in_valid = 1'b0;
        check("bp_fourth_accepted", int'(acc), 1);
        drain(10);
        check("bp_results", pops - pops0, 4);

        // Counter clear coinciding with an overflowing load wins.
        drive(3'd7, 3'd7, 1'b1);
        step();
        in_valid = 1'b0;
        clr_cnt  = 1'b1;
        step();
        clr_cnt  = 1'b0;
        check("clr_valid", int'(out_valid), 1);
        check("clr_result", int'({out_cout, out_sum}), 15);
        check("clr_priority", int'(ovf_cnt), 0);
        drive(3'd3, 3'd5, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        check("clr_then_inc", int'(ovf_cnt), 1);
        drain(4);

        // Asynchronous reset with a full FIFO and a pending result.
        out_ready = 1'b0;
        drive(3'd1, 3'd1, 1'b0);
        step();
        drive(3'd2, 3'd2, 1'b0);
        step();
        drive(3'd7, 3'd7, 1'b1);
        step();
        in_valid = 1'b0;
        check("pre_rst_occ", int'(occupancy), 2);
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_ovf", int'(ovf_cnt), 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_occ", int'(occupancy), 0);
        check("arst_ovf", int'(ovf_cnt), 0);
        check("arst_in_ready", int'(in_ready), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("arst_hold_occ", int'(occupancy), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(3'd6, 3'd1, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        check("after_rst_valid", int'(out_valid), 1);
        check("after_rst_result", int'({out_cout, out_sum}), 7);
        check("after_rst_ovf", int'(ovf_cnt), 0);
        drain(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
